// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: stimulus bit positions, key indices and debounce defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stopwatch_pkg;

    localparam int NUM_KEYS = 4;

    localparam int STIM_START_PAUSE = 5;
    localparam int STIM_LAP         = 4;
    localparam int STIM_RESET       = 3;
    localparam int STIM_CLEAR       = 2;
    localparam int STIM_LCD_BUSY    = 1;
    localparam int STIM_REG_BUSY    = 0;

    localparam int KEY_START_PAUSE = 0;
    localparam int KEY_LAP         = 1;
    localparam int KEY_RESET       = 2;
    localparam int KEY_CLEAR       = 3;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CNT_W_DEFAULT           = 19;

    typedef logic [1:0] key_idx_t;

    // Lowest-index set bit; tie-break for the optional press lockout.
    function automatic key_idx_t lowest_set(input logic [NUM_KEYS-1:0] v);
        key_idx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton: synchroniser, debounce counter, registered level and press pulse.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES cycles to level, one more cycle to the press pulse.
// Backpressure: none; free-running, consumers sample every cycle.
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q, stable_dly_d;
    logic                   press_q, press_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], ~key_n};
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sample;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Rising edge only; release and held levels produce nothing.
        press_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
        end
    end

    assign level       = stable_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/stimulus_conditioner.sv
// Debounces four active-low keys and packs them with the busy flags into the control_fsm stimulus.
// Latency: keys SYNC_STAGES+DEBOUNCE_CYCLES cycles, busy flags combinational; optional SIMUL_LOCKOUT_EN masks all but one key.
// Backpressure: none; outputs are levels and single-cycle pulses.
module stimulus_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       lcd_busy,
    input  logic       reg_busy,
    output logic [5:0] stimulus,
    output logic [3:0] press_event
);

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] press_raw;
    logic [NUM_KEYS-1:0] vis;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .key_n      (key_n[i]),
            .level      (stable[i]),
            .press_pulse(press_raw[i])
        );
    end

`ifdef SIMUL_LOCKOUT_EN
    logic                lock_vld_q, lock_vld_d;
    key_idx_t            lock_idx_q, lock_idx_d;
    logic [NUM_KEYS-1:0] vis_dly_q, vis_dly_d;
    logic [NUM_KEYS-1:0] press_q, press_d;

    // Owner keeps the lock while its level is high; on release the lock passes
    // straight to the lowest still-held key, which becomes visible next cycle.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (!lock_vld_q || !stable[lock_idx_q]) begin
            lock_vld_d = |stable;
            lock_idx_d = lowest_set(stable);
        end
        vis = '0;
        if (lock_vld_q) begin
            vis[lock_idx_q] = stable[lock_idx_q];
        end else if (|stable) begin
            vis[lowest_set(stable)] = 1'b1;
        end
        vis_dly_d = vis;
        press_d   = vis & ~vis_dly_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            vis_dly_q  <= '0;
            press_q    <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            vis_dly_q  <= vis_dly_d;
            press_q    <= press_d;
        end
    end

    assign press_event = press_q;
`else
    assign vis         = stable;
    assign press_event = press_raw;
`endif

    always_comb begin
        stimulus                   = '0;
        stimulus[STIM_START_PAUSE] = vis[KEY_START_PAUSE];
        stimulus[STIM_LAP]         = vis[KEY_LAP];
        stimulus[STIM_RESET]       = vis[KEY_RESET];
        stimulus[STIM_CLEAR]       = vis[KEY_CLEAR];
        stimulus[STIM_LCD_BUSY]    = lcd_busy;
        stimulus[STIM_REG_BUSY]    = reg_busy;
    end

endmodule

// File: doc/stimulus_conditioner.md
Name: stimulus_conditioner

Overview:
- Front end of the stopwatch control path.
- Takes four raw active-low pushbuttons, synchronises and debounces each one, and packs the clean levels with the two busy flags into the 6-bit stimulus bundle consumed by control_fsm.
- Also emits one-cycle press pulses for other consumers, such as the LCD refresh logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable samples needed to accept a level change (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SYNC_STAGES, 2, synchroniser depth per button; minimum 2.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key_n  input  4  raw pushbuttons, active low, asynchronous. [0]=start_pause, [1]=lap, [2]=reset button, [3]=clear.
- lcd_busy  input  1  LCD controller busy, already in the clock domain.
- reg_busy  input  1  timestamp register busy, already in the clock domain.
- stimulus  output  6  {start_pause, lap, reset_btn, clear, lcd_busy, reg_busy}, bits [5] down to [0].
- press_event  output  4  one-cycle pulse on each debounced press (0->1); same bit order as key_n.

Behaviour:
- Reset is synchronous and active high; it is the only reset in the block.
  - While reset is high: synchroniser flops load 0 (released), counters load 0, debounced levels load 0, press_event=0.
  - After reset: stimulus[5:2]=0, and stimulus[1:0] follow the busy inputs.
- Per channel:
  - Raw level is inverted (pressed=1), then passed through SYNC_STAGES flops giving sample.
  - stable is the registered debounced level.
- Counter rule per channel, each cycle:
  - If sample==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sample, cnt<=0.
  - Else: cnt<=cnt+1.
- Any disagreement shorter than DEBOUNCE_CYCLES cycles resets the count. Glitches never reach stimulus.
- Latency:
  - A clean press appears on stimulus exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first cycle key_n is low at the first sync flop.
  - Release has the same latency.
- press_event[i] is high for exactly one cycle, on the cycle after stable[i] rises; it is registered.
- Release produces no event.
- Holding a button never re-triggers; control_fsm relies on the level staying high until release.
- stimulus[5:2] are registered debounced levels. stimulus[1:0] are combinational pass-through of lcd_busy and reg_busy, with zero latency.
- Channels are fully independent. Simultaneous presses are each accepted on their own count; priority is resolved by control_fsm.
- Counter saturation cannot occur: the count is always cleared at DEBOUNCE_CYCLES-1.
- Reset asserted mid-count discards partial counts. A button held through reset is re-accepted DEBOUNCE_CYCLES after the synchroniser refills.

Optional Feature:
- Macro: SIMUL_LOCKOUT_EN.
- Defined:
  - A lock register holds the index of the first channel whose stable level rose.
  - While locked, other channels still debounce internally, but their stimulus bit and press_event are forced to 0.
  - The lock releases the cycle after the owning channel's stable level falls.
  - On a same-cycle tie, the lowest index wins.
  - Reset clears the lock.
- Not defined: channels are independent as described above; no lock register is built.

Decomposition:
- Shared package stopwatch_pkg holds:
  - stimulus bit index constants (STIM_START_PAUSE=5, STIM_LAP=4, STIM_RESET=3, STIM_CLEAR=2, STIM_LCD_BUSY=1, STIM_REG_BUSY=0);
  - key index constants KEY_START_PAUSE=0 .. KEY_CLEAR=3;
  - default DEBOUNCE_CYCLES.
- One sub-module, debounce_channel, contains the synchroniser, counter and stable/event logic. It is instantiated 4 times; lockout and packing sit in the top.

Test Plan (sim with DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Reset behaviour: hold reset 3 cycles with key_n=4'b0000 -> stimulus[5:2]=0 and press_event=0 during reset. Pressed levels appear 10 cycles after reset falls, with press_event pulses on all four bits for 1 cycle.
- Clean press: key_n[0] low at cycle 0 -> stimulus[5]=1 at cycle 10, press_event[0]=1 at cycle 11 only. Release at cycle 40 -> stimulus[5]=0 at cycle 50, no event.
- Glitch rejection: key_n[1] bounces low for 7 cycles, high 1 cycle, low 7 cycles -> stimulus[4] stays 0. Then held low 8 cycles -> stimulus[4]=1.
- Busy pass-through: toggle lcd_busy/reg_busy every cycle -> stimulus[1:0] match in the same cycle.
- Reset mid-count: key_n[3] low, reset pulsed at count 5 -> stimulus[2] rises 10 cycles after reset deasserts, not earlier.
- SIMUL_LOCKOUT_EN: press key 2, then key 0 three cycles later -> only stimulus[3] and press_event[2]. Release key 2 while key 0 is held -> stimulus[5] rises the cycle after the lock releases, with press_event[0]. Without the macro, both bits assert.
